branch_lut_loader: RTL and testbench
====================================

Name: branch_lut_loader

Overview:
- Programmable branch-target table. Holds 16 entries, each a 10-bit absolute instruction address.
- Written at boot by a byte-serial loader, which is the writer end of the table.
- Read combinationally by the fetch/branch logic through a 4-bit pointer.
- Replaces per-program hard-coded target lists: the host streams the target list for the running program before releasing the core.

Parameters:
- ENTRIES, 16, number of table entries. Must equal 2**PTR_W.
- PTR_W, 4, pointer width.
- ADDR_W, 10, absolute address width. Must be ≤ 10: the header byte carries 2 upper bits, the data byte carries 8.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- LoadValid  input  1  host byte valid.
- LoadByte  input  8  host byte.
- LoadReady  output  1  loader can accept a byte this cycle.
- LoadDone  output  1  one-cycle pulse when the END command is accepted.
- LoadErr  output  1  sticky flag: malformed header seen.
- TableValid  output  1  sticky: at least one END accepted since reset.
- LutPointer  input  4  read index.
- absaddress  output  10  entry[LutPointer]. Combinational read of the registered array.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - all entries = 0; state = HDR.
  - LoadReady = 1, LoadDone = 0, LoadErr = 0, TableValid = 0.
  - absaddress = 0 for any pointer.
- Byte transfer: a byte is accepted on a rising edge where LoadValid && LoadReady. The host may hold LoadValid high with no gaps.
- Header byte format: [7:4] = ptr, [3:2] = cmd, [1:0] = addr[9:8].
  - cmd 00 = WRITE.
  - cmd 11 = END.
  - cmd 01 or 10 = malformed.
- FSM states:
  - HDR (LoadReady = 1):
    - WRITE accepted: latch ptr and addr[9:8] -> DATA.
    - END accepted: LoadDone = 1 for exactly the next cycle; TableValid <= 1; stay in HDR.
    - Malformed accepted: LoadErr <= 1; byte dropped; stay in HDR.
  - DATA (LoadReady = 1): byte accepted = addr[7:0]; latch it -> COMMIT.
  - COMMIT (LoadReady = 0, exactly 1 cycle): entry[ptr] <= {addr_hi, addr_lo} on the edge leaving COMMIT -> HDR.
- Write latency: the new entry value is visible on absaddress the cycle after COMMIT. Reading the same pointer during COMMIT returns the old value. No bypass.
- LoadReady is registered. It is 0 only while in COMMIT, so the worst-case throughput is 3 cycles per entry.
- Bytes presented while LoadReady = 0 are not consumed. The host must hold them.
- Rewriting an entry overwrites it; the last write wins.
- Writes after END are permitted. TableValid stays 1.
- Flag clearing: LoadErr and TableValid are cleared only by reset.
- Reset mid-operation (DATA or COMMIT):
  - the pending write is discarded;
  - the table is cleared;
  - the FSM returns to HDR.
- Widths:
  - ptr is used unmodified (16 entries, no out-of-range case).
  - For ADDR_W < 10, the upper header/data bits are truncated.
- The read path has no sequential element. absaddress changes in the same cycle as LutPointer.

Test Plan:
1. Reset, then LutPointer sweep 0..15 -> absaddress = 0 on every pointer; LoadReady = 1; TableValid = 0.
2. Stream 0x30 0x2C (ptr 3, addr 0x02C = 44), then 0xF3 0x6E (ptr 15, addr 0x36E = 878), then 0x0C (END) with back-to-back LoadValid.
   - LoadReady drops for one cycle after each data byte.
   - LutPointer = 3 -> absaddress = 44; LutPointer = 15 -> absaddress = 878.
   - LoadDone pulses once; TableValid = 1.
3. Read pointer 3 while the write to ptr 3 is in COMMIT -> absaddress shows the old value (0) in COMMIT and the new value (0x12A) the next cycle.
4. Header 0x54 (cmd 01) -> LoadErr = 1; FSM stays in HDR. Next 0x50 0x0E -> entry 5 = 14; the load still succeeds.
5. Assert Reset_n low mid-cycle while in DATA after header 0x71 -> all outputs reset immediately. After release, entry 7 = 0 and state = HDR (next byte is treated as a header).
6. Write ptr 9 = 110, then ptr 9 = 1023 (0x93 0xFF) -> absaddress[9] = 1023. Other entries are unchanged.

Source files
------------

// File: rtl/branch_lut_loader.sv
// Programmable branch-target table: a byte-serial host loader fills 16 absolute
// target addresses at boot, and fetch logic reads them combinationally by pointer.
module branch_lut_loader #(
  parameter int ENTRIES = 16,
  parameter int PTR_W   = 4,
  parameter int ADDR_W  = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              LoadValid,
  input  logic [7:0]        LoadByte,
  output logic              LoadReady,
  output logic              LoadDone,
  output logic              LoadErr,
  output logic              TableValid,
  input  logic [PTR_W-1:0]  LutPointer,
  output logic [ADDR_W-1:0] absaddress
);

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    DATA   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_END   = 2'b11;

  state_t             state_q;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  logic               valid_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [1:0]         addr_hi_q;
  logic [7:0]         addr_lo_q;
  logic [ADDR_W-1:0]  table_q [ENTRIES];

  logic               accept_d;
  logic [9:0]         full_addr_d;
  logic [ADDR_W-1:0]  wr_data_d;

  assign accept_d    = LoadValid && ready_q;
  assign full_addr_d = {addr_hi_q, addr_lo_q};
  // Narrower tables keep only the low address bits.
  assign wr_data_d   = full_addr_d[ADDR_W-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= HDR;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        HDR: begin
          if (accept_d) begin
            case (LoadByte[3:2])
              CMD_WRITE: begin
                ptr_q     <= LoadByte[4 +: PTR_W];
                addr_hi_q <= LoadByte[1:0];
                state_q   <= DATA;
              end
              CMD_END: begin
                done_q  <= 1'b1;
                valid_q <= 1'b1;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        DATA: begin
          if (accept_d) begin
            addr_lo_q <= LoadByte;
            state_q   <= COMMIT;
            ready_q   <= 1'b0;
          end
        end
        COMMIT: begin
          state_q <= HDR;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= HDR;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Each entry is its own register so the whole table clears on reset.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        table_q[gi] <= '0;
      end else if (state_q == COMMIT && ptr_q == PTR_W'(gi)) begin
        table_q[gi] <= wr_data_d;
      end
    end
  end

  assign absaddress = table_q[LutPointer];
  assign LoadReady  = ready_q;
  assign LoadDone   = done_q;
  assign LoadErr    = err_q;
  assign TableValid = valid_q;

endmodule

// File: tb/tb_branch_lut_loader.sv
// Bench for branch_lut_loader: vector table of writes, scoreboard of pending
// entry values, plus hand-built sequences for commit timing, errors and reset.
module tb_branch_lut_loader;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       LoadValid;
  logic [7:0] LoadByte;
  logic       LoadReady;
  logic       LoadDone;
  logic       LoadErr;
  logic       TableValid;
  logic [3:0] LutPointer;
  logic [9:0] absaddress;

  always #5 Clk = ~Clk;

  branch_lut_loader dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .LoadValid  (LoadValid),
    .LoadByte   (LoadByte),
    .LoadReady  (LoadReady),
    .LoadDone   (LoadDone),
    .LoadErr    (LoadErr),
    .TableValid (TableValid),
    .LutPointer (LutPointer),
    .absaddress (absaddress)
  );

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] dat;
    logic [3:0] ptr;
    logic [9:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] ptr;
    logic [9:0] exp;
  } sb_t;

  vec_t       vecs [5];
  sb_t        sbq [$];
  logic [9:0] model [16];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;

  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && LoadDone === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge Clk);
    #1;
  endtask

  // Present a byte and hold it until it is accepted; reports stall cycles.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    logic rdy;
    logic acc;
    stalls    = 0;
    acc       = 1'b0;
    LoadValid = 1'b1;
    LoadByte  = b;
    for (int k = 0; k < 8 && !acc; k++) begin
      @(negedge Clk);
      rdy = LoadReady;
      @(posedge Clk);
      #1;
      if (rdy === 1'b1) acc = 1'b1;
      else stalls++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte %h got no acceptance expected acceptance within 8 cycles", b);
    end
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      LutPointer = e.ptr;
      #1;
      $display("entry[%0d] read %0d expected %0d", e.ptr, absaddress, e.exp);
      check("entry_write", absaddress, e.exp);
      model[e.ptr] = e.exp;
    end
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < 16; i++) begin
      LutPointer = 4'(i);
      #1;
      check(name, absaddress, model[i]);
    end
    sync();
  endtask

  task automatic run_vec(input int lo, input int hi, input bit each);
    int   s;
    sb_t  e;
    for (int i = lo; i <= hi; i++) begin
      send_byte(vecs[i].hdr, s);
      $display("hdr %h accepted after %0d stalls", vecs[i].hdr, s);
      check("hdr_stall", 32'(s), (i > lo && !each) ? 32'd1 : 32'd0);
      send_byte(vecs[i].dat, s);
      $display("data %h accepted after %0d stalls", vecs[i].dat, s);
      check("data_stall", 32'(s), 32'd0);
      e.ptr = vecs[i].ptr;
      e.exp = vecs[i].exp;
      sbq.push_back(e);
      if (each) begin
        LoadValid = 1'b0;
        sync();
        drain();
        sync();
      end
    end
  endtask

  int s;
  int d0;

  initial begin
    vecs[0] = '{8'h30, 8'h2C, 4'd3,  10'd44};
    vecs[1] = '{8'hF3, 8'h6E, 4'd15, 10'd878};
    vecs[2] = '{8'h50, 8'h0E, 4'd5,  10'd14};
    vecs[3] = '{8'h90, 8'h6E, 4'd9,  10'd110};
    vecs[4] = '{8'h93, 8'hFF, 4'd9,  10'd1023};
    for (int i = 0; i < 16; i++) model[i] = '0;

    Reset_n    = 1'b0;
    LoadValid  = 1'b0;
    LoadByte   = '0;
    LutPointer = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    sync();

    // Reset state
    check("rst_ready", LoadReady, 1);
    check("rst_tvalid", TableValid, 0);
    check("rst_err", LoadErr, 0);
    check("rst_done", LoadDone, 0);
    check_all("rst_sweep");

    // Same-pointer read during COMMIT shows the old value
    LutPointer = 4'd3;
    send_byte(8'h31, s);
    send_byte(8'h2A, s);
    LoadValid = 1'b0;
    #2;
    check("commit_old", absaddress, 0);
    check("commit_ready", LoadReady, 0);
    sync();
    check("commit_new", absaddress, 10'h12A);
    check("commit_ready_back", LoadReady, 1);
    model[3] = 10'h12A;
    sync();

    // Back-to-back stream of two writes then END
    d0 = done_cnt;
    run_vec(0, 1, 1'b0);
    send_byte(8'h0C, s);
    LoadValid = 1'b0;
    check("end_stall", 32'(s), 1);
    check("end_done", LoadDone, 1);
    check("end_tvalid", TableValid, 1);
    sync();
    check("done_cleared", LoadDone, 0);
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("no_err", LoadErr, 0);
    drain();
    sync();

    // Malformed header then a good write
    send_byte(8'h54, s);
    LoadValid = 1'b0;
    check("malformed_err", LoadErr, 1);
    check("malformed_ready", LoadReady, 1);
    sync();
    run_vec(2, 2, 1'b1);
    send_byte(8'h0C, s);
    LoadValid = 1'b0;
    check("end2_done", LoadDone, 1);
    sync();
    check("err_sticky", LoadErr, 1);
    check_all("sweep_loaded");

    // Asynchronous reset while in DATA
    send_byte(8'h71, s);
    LoadValid  = 1'b0;
    LutPointer = 4'd3;
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst_ready", LoadReady, 1);
    check("arst_done", LoadDone, 0);
    check("arst_err", LoadErr, 0);
    check("arst_tvalid", TableValid, 0);
    check("arst_entry", absaddress, 0);
    sync();
    sync();
    Reset_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    sync();
    check_all("post_rst_sweep");
    send_byte(8'h72, s);
    send_byte(8'h05, s);
    LoadValid = 1'b0;
    sync();
    LutPointer = 4'd7;
    #1;
    check("post_rst_hdr", absaddress, 517);
    check("post_rst_err", LoadErr, 0);
    model[7] = 10'd517;
    sync();

    // Rewrite: last write wins
    run_vec(3, 4, 1'b1);
    check_all("rewrite_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time got 200000 expected completion earlier");
    $fatal(1);
  end

endmodule
